// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffered issue/retire wrapper around a combinational ALU.
// Commands queue in a DEPTH-entry FIFO. The FIFO head drives the ALU, and the
// ALU result is captured into a registered output with a valid/ready handshake.
// Latency: an accepted command is presented on out_* two edges after acceptance.
// Backpressure: in_ready = (count < DEPTH), taken from registered state only.
//   The head is held while out_valid && !out_ready.
// Optional feature macro: ALU_DIVZERO_CHECK_EN (divide-by-zero error retire).
// Ports:
//   clk, rst                            clock, async active-high reset
//   in_valid/in_ready, in_a/in_b/in_op/in_setflags      command input
//   alu_a/alu_b/alu_ctrl -> ALU,  alu_result/alu_flags <- ALU
//   out_valid/out_ready, out_result/out_flags/out_err   retired result
//   nzcv                                architectural flags {N,Z,C,V}
//   count                               FIFO occupancy
module alu_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [3:0]               in_op,
  input  logic                     in_setflags,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_ctrl,
  input  logic [31:0]              alu_result,
  input  logic [3:0]               alu_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_flags,
  output logic                     out_err,
  output logic [3:0]               nzcv,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Command storage; contents are only observed when count != 0,
  // so the array needs no reset.
  logic [31:0]   mem_a  [DEPTH];
  logic [31:0]   mem_b  [DEPTH];
  logic [3:0]    mem_op [DEPTH];
  logic          mem_sf [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          push;
  logic          pop;
  logic          empty;
  logic          err;
  logic [31:0]   head_a;
  logic [31:0]   head_b;
  logic [3:0]    head_op;
  logic          head_sf;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Capture whenever the output register is free or being drained this cycle.
  assign pop      = !empty && (!out_valid || out_ready);

  assign head_a  = mem_a[rd_ptr];
  assign head_b  = mem_b[rd_ptr];
  assign head_op = mem_op[rd_ptr];
  assign head_sf = mem_sf[rd_ptr];

  assign alu_a    = empty ? 32'd0 : head_a;
  assign alu_b    = empty ? 32'd0 : head_b;
  assign alu_ctrl = empty ? 4'd0  : head_op;

`ifdef ALU_DIVZERO_CHECK_EN
  assign err = (head_op == 4'b0011) && (head_b == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err <= 1'b0;
    end else if (pop) begin
      out_err <= err;
    end
  end
`else
  assign err     = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= in_a;
      mem_b[wr_ptr]  <= in_b;
      mem_op[wr_ptr] <= in_op;
      mem_sf[wr_ptr] <= in_setflags;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Output register and architectural flags. A drain without refill only
  // clears out_valid; the result and flags keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_flags  <= 4'd0;
      nzcv       <= 4'd0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= err ? 32'hFFFF_FFFF : alu_result;
      out_flags  <= err ? 4'b1000 : alu_flags;
      if (head_sf && !err) nzcv <= alu_flags;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
